// File: rtl/spi_reg_pkg.sv
// Shared constants, frame layout and FSM states for the SPI register-config block.
// Latency: n/a (definitions only); backpressure: n/a.
package spi_reg_pkg;

  localparam int         FRAME_BITS = 16;
  localparam logic [4:0] CNT_FULL   = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT    = 5'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] dat;
  } frame_t;

endpackage

// File: rtl/spi_reg_config_sync_edge.sv
// Multi-flop synchroniser for one async pin plus rising/falling edge detect.
// Latency: STAGES cycles to level/edge outputs; backpressure: none.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_config.sv
// SPI mode-0 write-only controller committing 16-bit frames into five PWM config registers.
// Latency: registers update SYNC_STAGES+2 clk after ncs rises; backpressure: none (SPI timing assumed).
module spi_reg_config
  import spi_reg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       commit
);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_copi_lvl, w_copi_rise, w_copi_fall;
  logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (sclk),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (copi),
    .o_level (w_copi_lvl),
    .o_rise  (w_copi_rise),
    .o_fall  (w_copi_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (ncs),
    .o_level (w_ncs_lvl),
    .o_rise  (w_ncs_rise),
    .o_fall  (w_ncs_fall)
  );

  // Only sclk rise, ncs edges and the copi level drive the datapath.
  logic w_unused;
  assign w_unused = ^{w_sclk_lvl, w_sclk_fall, w_copi_rise, w_copi_fall, w_ncs_lvl};

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  frame_t      w_frame;
  logic        w_clear, w_shift_en, w_wr_en;

  logic [7:0]  r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;

  assign w_frame = r_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An ncs rise in SHIFT takes priority, so a coincident sclk rise is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_shift_en  = 1'b0;
    w_wr_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ncs_fall) begin
          w_clear     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ncs_rise) begin
          w_state_nxt = COMMIT;
        end else if (w_sclk_rise) begin
          w_shift_en = 1'b1;
        end
      end
      COMMIT: begin
        w_wr_en     = (r_cnt == CNT_FULL) && w_frame.wr && (w_frame.addr <= MAX_ADDR);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Counter saturates at 17 so any overlong frame can never look like exactly 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[14:0], w_copi_lvl};
      if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_out_lo <= '0;
      r_en_out_hi <= '0;
      r_en_pwm_lo <= '0;
      r_en_pwm_hi <= '0;
      r_duty      <= '0;
    end else if (w_wr_en) begin
      unique case (w_frame.addr)
        ADDR_EN_OUT_7_0:  r_en_out_lo <= w_frame.dat;
        ADDR_EN_OUT_15_8: r_en_out_hi <= w_frame.dat;
        ADDR_EN_PWM_7_0:  r_en_pwm_lo <= w_frame.dat;
        ADDR_EN_PWM_15_8: r_en_pwm_hi <= w_frame.dat;
        ADDR_PWM_DUTY:    r_duty      <= w_frame.dat;
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign commit          = w_wr_en;

endmodule

// File: tb/tb_spi_reg_config.sv
// Directed plus randomised SPI frames against a register-file reference model.
module tb_spi_reg_config;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       commit;

  spi_reg_config dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .commit          (commit)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         commit_cnt = 0;
  int         exp_commits = 0;
  logic [7:0] m [5];

  always @(negedge clk) if (commit === 1'b1) commit_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dut_reg(input int a);
    case (a)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      4: return pwm_duty_cycle;
      default: return 8'h00;
    endcase
  endfunction

  // Reference rule: only an exact 16-bit write frame to address 0..4 lands.
  task automatic model_apply(input logic [31:0] f, input int nb);
    if (nb == 16 && f[15] && f[14:8] <= 7'd4) begin
      m[f[14:8]] = f[7:0];
      exp_commits++;
    end
  endtask

  task automatic sclk_bit(input logic b);
    copi = b;
    tick(5);
    sclk = 1'b1;
    tick(5);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f, input int nb);
    ncs = 1'b0;
    tick(5);
    for (int i = 0; i < nb; i++) sclk_bit(f[nb-1-i]);
    tick(5);
    ncs = 1'b1;
  endtask

  task automatic check_all(input string tag);
    tick(6);
    for (int a = 0; a < 5; a++) check($sformatf("%s_r%0d", tag, a), 32'(dut_reg(a)), 32'(m[a]));
    check({tag, "_commits"}, commit_cnt, exp_commits);
  endtask

  task automatic lat_frame(input logic [15:0] f, input string tag);
    int         a;
    logic [7:0] old;
    a   = int'(f[14:8]);
    old = m[a];
    send_frame(32'(f), 16);
    tick(3);
    check({tag, "_commit_hi"}, 32'(commit), 32'd1);
    check({tag, "_not_yet"}, 32'(dut_reg(a)), 32'(old));
    tick(1);
    check({tag, "_updated"}, 32'(dut_reg(a)), 32'(f[7:0]));
    check({tag, "_commit_lo"}, 32'(commit), 32'd0);
    model_apply(32'(f), 16);
  endtask

  initial begin
    logic [31:0] f;
    int          nb;
    for (int a = 0; a < 5; a++) m[a] = 8'h00;
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    tick(3);
    for (int a = 0; a < 5; a++) check($sformatf("rst_r%0d", a), 32'(dut_reg(a)), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    rst_n = 1'b1;
    tick(4);

    send_frame(32'h8455, 16); model_apply(32'h8455, 16); check_all("duty55");

    lat_frame(16'h80FF, "out_lo");
    lat_frame(16'h81F0, "out_hi");
    check_all("out_pair");

    send_frame(32'h0455, 16); model_apply(32'h0455, 16); check_all("read");
    send_frame(32'h8555, 16); model_apply(32'h8555, 16); check_all("addr5");
    send_frame(32'h0433, 15); model_apply(32'h0433, 15); check_all("short15");
    send_frame(32'h18433, 17); model_apply(32'h18433, 17); check_all("long17");

    // Reset after bit 9 of a write; the tail after release is a short frame.
    ncs = 1'b0;
    tick(5);
    f = 32'h8477;
    for (int i = 0; i < 9; i++) sclk_bit(f[15-i]);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) m[a] = 8'h00;
    for (int i = 9; i < 16; i++) sclk_bit(f[15-i]);
    tick(5);
    ncs = 1'b1;
    check_all("midrst");
    send_frame(32'h8201, 16); model_apply(32'h8201, 16); check_all("after_rst");

    for (int i = 0; i < 32; i++) begin
      copi = 1'($urandom);
      tick(5);
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
    check_all("idle_sclk");
    send_frame(32'h83AA, 16); model_apply(32'h83AA, 16); check_all("pwm_hi");

    send_frame(32'h8411, 16); model_apply(32'h8411, 16);
    tick(4);
    send_frame(32'h8422, 16); model_apply(32'h8422, 16);
    check_all("b2b");

    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0:       nb = 15;
        1:       nb = 17;
        default: nb = 16;
      endcase
      f = $urandom;
      if (nb == 16) f = {16'h0, ($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
      send_frame(f, nb);
      model_apply(f, nb);
      check_all($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
